rx_cmd_sequencer: RTL and testbench

- Command-level controller behind the UART receive path.
- Consumes synchronized received bytes (one valid pulse per byte) and decodes multi-byte command frames.
- Sequences the register file and ALU, then hands result bytes to the UART transmit path.
- Sits in the system-clock domain between the RX data synchronizer and the RF/ALU/TX blocks.

---
 rtl/rx_cmd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rx_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_sequencer.sv
// Command sequencer behind the UART receive path: decodes multi-byte frames,
// drives register file / ALU accesses and returns result bytes to the transmitter.
module rx_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_Valid,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY
);

  localparam int unsigned FUN_W = 4;
  localparam int unsigned RES_W = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] OPC_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU_NO = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN_S, ALU_WAIT, TX_RD, TX_LO, TX_HI
  } state_t;

  // Transmit byte handshake: send, then observe TX_BUSY rise and fall.
  typedef enum logic [1:0] {
    PH_SEND, PH_WAIT_HI, PH_WAIT_LO
  } tx_phase_t;

  state_t                  r_state;
  tx_phase_t               r_tx_phase;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic [RES_W-1:0]        r_alu_res;
  logic [DATA_WIDTH-1:0]   w_tx_byte;

  always_comb begin
    w_tx_byte = r_rd_data;
    case (r_state)
      TX_LO:   w_tx_byte = r_alu_res[DATA_WIDTH-1:0];
      TX_HI:   w_tx_byte = r_alu_res[RES_W-1:DATA_WIDTH];
      default: w_tx_byte = r_rd_data;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_tx_phase  <= PH_SEND;
      r_addr      <= '0;
      r_rd_data   <= '0;
      r_alu_res   <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_Address  <= '0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      TX_D_VLD <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_phase <= PH_SEND;
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              OPC_WR:     r_state <= WR_ADDR;
              OPC_RD:     r_state <= RD_ADDR;
              OPC_ALU_OP: r_state <= OP_A;
              OPC_ALU_NO: r_state <= ALU_FUN_S;
              default:    r_state <= IDLE;
            endcase
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WrEn    <= 1'b1;
            RF_Address <= r_addr;
            RF_WrData  <= RX_P_DATA;
            r_state    <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_RdEn    <= 1'b1;
            RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (RF_RdData_Valid) begin
            r_rd_data <= RF_RdData;
            r_state   <= TX_RD;
          end
        end
        OP_A: begin
          if (RX_D_VLD) begin
            RF_WrEn    <= 1'b1;
            RF_Address <= ADDR_WIDTH'(0);
            RF_WrData  <= RX_P_DATA;
            r_state    <= OP_B;
          end
        end
        OP_B: begin
          if (RX_D_VLD) begin
            RF_WrEn    <= 1'b1;
            RF_Address <= ADDR_WIDTH'(1);
            RF_WrData  <= RX_P_DATA;
            r_state    <= ALU_FUN_S;
          end
        end
        ALU_FUN_S: begin
          if (RX_D_VLD) begin
            ALU_FUN     <= RX_P_DATA[FUN_W-1:0];
            ALU_EN      <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            r_state     <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            r_alu_res   <= ALU_OUT;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            r_state     <= TX_LO;
          end
        end
        TX_RD, TX_LO, TX_HI: begin
          case (r_tx_phase)
            PH_SEND: begin
              if (!TX_BUSY) begin
                TX_P_DATA  <= w_tx_byte;
                TX_D_VLD   <= 1'b1;
                r_tx_phase <= PH_WAIT_HI;
              end
            end
            PH_WAIT_HI: begin
              if (TX_BUSY) r_tx_phase <= PH_WAIT_LO;
            end
            PH_WAIT_LO: begin
              if (!TX_BUSY) begin
                r_tx_phase <= PH_SEND;
                r_state    <= (r_state == TX_LO) ? TX_HI : IDLE;
              end
            end
            default: r_tx_phase <= PH_SEND;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer with small RF, ALU and transmitter models.
module tb_rx_cmd_sequencer;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [3:0]  RF_Address;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;

  logic        model_busy;
  logic        force_busy;
  assign TX_BUSY = model_busy | force_busy;

  rx_cmd_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  logic [3:0] alu_q[$];
  logic [7:0] tx_q[$];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rd_resp;
  logic [15:0] alu_resp;
  int          alu_lat;
  logic        hold_busy;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_wren"},  32'(RF_WrEn), 32'd0);
    chk({tag, "_rden"},  32'(RF_RdEn), 32'd0);
    chk({tag, "_addr"},  32'(RF_Address), 32'd0);
    chk({tag, "_wdata"}, 32'(RF_WrData), 32'd0);
    chk({tag, "_aluen"}, 32'(ALU_EN), 32'd0);
    chk({tag, "_fun"},   32'(ALU_FUN), 32'd0);
    chk({tag, "_cge"},   32'(CLK_GATE_EN), 32'd0);
    chk({tag, "_txd"},   32'(TX_P_DATA), 32'd0);
    chk({tag, "_txv"},   32'(TX_D_VLD), 32'd0);
  endtask

  // Bounded wait for all expected events, then let the DUT settle.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: pending wr=%0d rd=%0d alu=%0d tx=%0d expected all 0",
               tag, wr_q.size(), rd_q.size(), alu_q.size(), tx_q.size());
    end
    repeat (12) @(posedge CLK);
    #1;
  endtask

  // Register file read responder.
  initial begin
    RF_RdData       = '0;
    RF_RdData_Valid = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (RF_RdEn) begin
        @(posedge CLK); #1;
        RF_RdData       = rd_resp;
        RF_RdData_Valid = 1'b1;
        @(posedge CLK); #1;
        RF_RdData_Valid = 1'b0;
      end
    end
  end

  // ALU responder; optionally holds the transmitter busy after the result.
  initial begin
    logic prev_en;
    prev_en       = 1'b0;
    ALU_OUT       = '0;
    ALU_OUT_VALID = 1'b0;
    force_busy    = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (ALU_EN && !prev_en) begin
        repeat (alu_lat - 1) begin
          @(posedge CLK); #1;
        end
        ALU_OUT       = alu_resp;
        ALU_OUT_VALID = 1'b1;
        @(posedge CLK); #1;
        ALU_OUT_VALID = 1'b0;
        if (hold_busy) begin
          force_busy = 1'b1;
          repeat (20) @(posedge CLK);
          #1;
          force_busy = 1'b0;
        end
      end
      prev_en = ALU_EN;
    end
  end

  // Transmitter model: busy for a few cycles after each request.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (TX_D_VLD) begin
        model_busy = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  // Monitor: compare every DUT strobe against the scoreboard queues.
  initial begin
    logic mon_prev_en, prev_busy, drop_pending, tx_any;
    int   hs;
    wr_t  w;
    mon_prev_en  = 1'b0;
    prev_busy    = 1'b0;
    drop_pending = 1'b0;
    tx_any       = 1'b0;
    hs           = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (RF_WrEn) begin
          if (wr_q.size() == 0) chk("unexpected_wren", 32'd1, 32'd0);
          else begin
            w = wr_q.pop_front();
            chk("wr_addr", 32'(RF_Address), 32'(w.addr));
            chk("wr_data", 32'(RF_WrData), 32'(w.data));
          end
        end
        if (RF_RdEn) begin
          if (rd_q.size() == 0) chk("unexpected_rden", 32'd1, 32'd0);
          else chk("rd_addr", 32'(RF_Address), 32'(rd_q.pop_front()));
        end
        if (ALU_EN && !mon_prev_en) begin
          if (alu_q.size() == 0) chk("unexpected_alu_en", 32'd1, 32'd0);
          else begin
            chk("alu_fun", 32'(ALU_FUN), 32'(alu_q.pop_front()));
            chk("alu_cge_on", 32'(CLK_GATE_EN), 32'd1);
          end
        end
        if (drop_pending) begin
          chk("alu_en_drop", 32'({ALU_EN, CLK_GATE_EN}), 32'd0);
          drop_pending = 1'b0;
        end
        if (ALU_OUT_VALID) begin
          chk("alu_en_until_valid", 32'({ALU_EN, CLK_GATE_EN}), 32'd3);
          drop_pending = 1'b1;
        end
        if (TX_D_VLD) begin
          if (tx_any) chk("tx_handshake", 32'({hs == 2, prev_busy}), 32'b10);
          else chk("tx_not_busy", 32'(prev_busy), 32'd0);
          tx_any = 1'b1;
          hs     = 1;
          if (tx_q.size() == 0) chk("unexpected_tx", 32'd1, 32'd0);
          else chk("tx_data", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
        end else if (hs == 1 && TX_BUSY) begin
          hs = 2;
        end
      end
      mon_prev_en = ALU_EN;
      prev_busy   = TX_BUSY;
    end
  end

  initial begin
    RST       = 1'b1;
    RX_P_DATA = '0;
    RX_D_VLD  = 1'b0;
    rd_resp   = '0;
    alu_resp  = '0;
    alu_lat   = 3;
    hold_busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    RST = 1'b0;

    // Register write
    wr_q.push_back('{addr: 4'h5, data: 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("write");

    // Register read and echo
    rd_resp = 8'h5A;
    rd_q.push_back(4'h7);
    tx_q.push_back(8'h5A);
    send(8'hBB); send(8'h07);
    drain("read");

    // ALU with operands
    alu_lat  = 3;
    alu_resp = 16'h0046;
    wr_q.push_back('{addr: 4'h0, data: 8'h12});
    wr_q.push_back('{addr: 4'h1, data: 8'h34});
    alu_q.push_back(4'h0);
    tx_q.push_back(8'h46);
    tx_q.push_back(8'h00);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
    drain("alu_op");

    // Stray byte, write, then a byte dropped during ALU_WAIT
    wr_q.push_back('{addr: 4'h1, data: 8'hFF});
    send(8'h55); send(8'hAA); send(8'h01); send(8'hFF);
    drain("stray");
    alu_lat  = 8;
    alu_resp = 16'h1234;
    alu_q.push_back(4'h3);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'h12);
    send(8'hDD); send(8'h03); send(8'hBB);
    drain("alu_drop");

    // Reset mid-frame abandons the write
    send(8'hAA); send(8'h03);
    RST = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(posedge CLK); #1;
    RST = 1'b0;
    send(8'h77);
    wr_q.push_back('{addr: 4'h2, data: 8'h11});
    send(8'hAA); send(8'h02); send(8'h11);
    drain("after_rst");

    // ALU without operands, transmitter held busy
    hold_busy = 1'b1;
    alu_lat   = 2;
    alu_resp  = 16'hBEEF;
    alu_q.push_back(4'h2);
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    send(8'hDD); send(8'h02);
    drain("busy_hold");
    hold_busy = 1'b0;

    chk("queues_empty", 32'(wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
